// File: rtl/tisc_pkg.sv
// tisc_pkg: shared opcode map, ALU select codes and the decoded control
// bundle used by the TISC control unit and its hazard scoreboard.
package tisc_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Number of register read ports an ID instruction can use (rs1, rs2, rd).
  localparam int NUM_RD = 3;

  typedef struct packed {
    logic [1:0] alu_sel;
    logic       reg_write_en;
    logic       mem_write_en;
    logic       mem_to_reg;
    logic       mem_op;
  } ctrl_t;

endpackage

// File: rtl/tisc_ctrl_unit_if.sv
// tisc_ctrl_unit_if: datapath <-> control unit bundle.
//   master (datapath): drives opcode/rd/rs1/rs2, receives strobes and status.
//   slave  (control) : the reverse.
interface tisc_ctrl_unit_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 8
);
  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [1:0]        alu_sel;
  logic              reg_write_en;
  logic              mem_write_en;
  logic              mem_to_reg;
  logic              mem_op;
  logic              stall;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output opcode, rd, rs1, rs2,
    input  alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
           stall, halted, illegal, stall_cnt
  );

  modport slave (
    input  opcode, rd, rs1, rs2,
    output alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
           stall, halted, illegal, stall_cnt
  );
endinterface

// File: rtl/tisc_hazard_sb.sv
// tisc_hazard_sb: in-flight writer scoreboard (EX, MEM, WB slots) plus the
// RAW comparator against the registers read by the ID instruction.
//   clk, rst       : clock, async active-high reset
//   in_valid/addr  : writer entering EX this edge (0 for a bubble)
//   rd_en/rd_addr  : per read port enable and register address in ID
//   hazard         : some valid slot writes a register ID reads
module tisc_hazard_sb
  import tisc_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [REG_AW-1:0]              in_addr,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][REG_AW-1:0]  rd_addr,
  output logic                           hazard
);

  // Slot 0 = EX, slot HAZ_DEPTH-1 = WB.
  logic [HAZ_DEPTH-1:0]             slot_vld;
  logic [HAZ_DEPTH-1:0][REG_AW-1:0] slot_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld  <= '0;
      slot_addr <= '0;
    end else begin
      slot_vld  <= {slot_vld[HAZ_DEPTH-2:0], in_valid};
      slot_addr <= {slot_addr[HAZ_DEPTH-2:0], in_addr};
    end
  end

  // WB is included: the register file writes at the end of WB, so ID
  // would still read the stale value in that cycle.
  logic [HAZ_DEPTH-1:0] slot_hit;

  for (genvar s = 0; s < HAZ_DEPTH; s++) begin : g_slot
    always_comb begin
      slot_hit[s] = 1'b0;
      for (int r = 0; r < NUM_RD; r++)
        if (slot_vld[s] && rd_en[r] && (slot_addr[s] == rd_addr[r]))
          slot_hit[s] = 1'b1;
    end
  end

  assign hazard = |slot_hit;

endmodule

// File: rtl/tisc_ctrl_unit.sv
// tisc_ctrl_unit: TISC control and hazard unit.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of tisc_ctrl_unit_if
//              in : opcode, rd, rs1, rs2 (ID-stage fields)
//              out: alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
//                   stall, halted, illegal, stall_cnt
module tisc_ctrl_unit
  import tisc_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  tisc_ctrl_unit_if.slave  bus
);

  ctrl_t             raw;
  ctrl_t             ctrl;
  logic [NUM_RD-1:0] rd_en;
  logic              legal;
  logic              is_halt;
  logic              hazard;
  logic              stall;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  stall_cnt;

  // Raw decode of the ID fields; read enables are {rd, rs2, rs1}.
  always_comb begin
    raw     = '0;
    rd_en   = '0;
    legal   = 1'b1;
    is_halt = 1'b0;
    case (bus.opcode)
      OP_NOP:   ;
      OP_ADD:   begin raw.alu_sel = ALU_ADD; raw.reg_write_en = 1'b1; rd_en = 3'b011; end
      OP_SUB:   begin raw.alu_sel = ALU_SUB; raw.reg_write_en = 1'b1; rd_en = 3'b011; end
      OP_AND:   begin raw.alu_sel = ALU_AND; raw.reg_write_en = 1'b1; rd_en = 3'b011; end
      OP_OR:    begin raw.alu_sel = ALU_OR;  raw.reg_write_en = 1'b1; rd_en = 3'b011; end
      OP_LOAD:  begin raw.mem_op = 1'b1; raw.mem_to_reg = 1'b1; raw.reg_write_en = 1'b1; end
      OP_STORE: begin raw.mem_op = 1'b1; raw.mem_write_en = 1'b1; rd_en = 3'b100; end
      OP_HALT:  is_halt = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  tisc_hazard_sb #(
    .REG_AW    (REG_AW),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ctrl.reg_write_en),
    .in_addr  (bus.rd),
    .rd_en    (rd_en),
    .rd_addr  ({bus.rd, bus.rs2, bus.rs1}),
    .hazard   (hazard)
  );

  // Once halted the front end is frozen for good; only bubbles issue.
  assign stall = !rst && (halted || hazard);
  assign ctrl  = (stall || halted || rst) ? '0 : raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted    <= 1'b0;
      illegal   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // A stalled HALT or bad opcode has not issued yet.
      if (is_halt && !stall) halted  <= 1'b1;
      if (!legal && !stall)  illegal <= 1'b1;
      if (stall && !halted && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.alu_sel      = ctrl.alu_sel;
  assign bus.reg_write_en = ctrl.reg_write_en;
  assign bus.mem_write_en = ctrl.mem_write_en;
  assign bus.mem_to_reg   = ctrl.mem_to_reg;
  assign bus.mem_op       = ctrl.mem_op;
  assign bus.stall        = stall;
  assign bus.halted       = halted;
  assign bus.illegal      = illegal;
  assign bus.stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_tisc_ctrl_unit.sv
// tb_tisc_ctrl_unit: directed bench for tisc_ctrl_unit. Inputs change 1ns
// after the rising edge and outputs are sampled 1ns later.
module tb_tisc_ctrl_unit;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n;

  always #5 clk = ~clk;

  tisc_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus_if ();

  tisc_ctrl_unit #(.REG_AW(REG_AW), .HAZ_DEPTH(3), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
    bus_if.opcode = op;
    bus_if.rd     = d;
    bus_if.rs1    = s1;
    bus_if.rs2    = s2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles until the held instruction issues (bounded).
  task automatic wait_issue(output int cnt);
    cnt = 0;
    while (bus_if.stall && cnt < 12) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with a live ADD on the fields: everything must be bubbled.
    drive(4'h1, 4'd1, 4'd2, 4'd3);
    #1;
    chk("rst_stall",   bus_if.stall, 0);
    chk("rst_halted",  bus_if.halted, 0);
    chk("rst_illegal", bus_if.illegal, 0);
    chk("rst_cnt",     bus_if.stall_cnt, 0);
    chk("rst_rwe",     bus_if.reg_write_en, 0);
    @(negedge clk);
    rst = 1'b0;

    // Independent ops: ADD r1,r2,r3 / SUB r4,r5,r6 / OR r7,r8,r9
    drive(4'h1, 4'd1, 4'd2, 4'd3);
    chk("ind_add_alu", bus_if.alu_sel, 2'b00);
    chk("ind_add_rwe", bus_if.reg_write_en, 1);
    chk("ind_add_stl", bus_if.stall, 0);
    tick();
    drive(4'h2, 4'd4, 4'd5, 4'd6);
    chk("ind_sub_alu", bus_if.alu_sel, 2'b01);
    chk("ind_sub_rwe", bus_if.reg_write_en, 1);
    chk("ind_sub_stl", bus_if.stall, 0);
    tick();
    drive(4'h4, 4'd7, 4'd8, 4'd9);
    chk("ind_or_alu", bus_if.alu_sel, 2'b11);
    chk("ind_or_rwe", bus_if.reg_write_en, 1);
    chk("ind_or_stl", bus_if.stall, 0);
    tick();

    // EX dependency: ADD r1 then AND r5,r1,r1 -> 3 stalls
    drive(4'h1, 4'd1, 4'd2, 4'd3);
    chk("ex_add_stl", bus_if.stall, 0);
    tick();
    drive(4'h3, 4'd5, 4'd1, 4'd1);
    chk("ex_and_stl", bus_if.stall, 1);
    chk("ex_and_bub", bus_if.reg_write_en, 0);
    wait_issue(n);
    chk("ex_stalls", n, 3);
    chk("ex_and_alu", bus_if.alu_sel, 2'b10);
    chk("ex_and_rwe", bus_if.reg_write_en, 1);
    chk("ex_cnt", bus_if.stall_cnt, 3);
    tick();

    // LOAD r3 then STORE r3 -> 3 stalls
    drive(4'h8, 4'd3, 4'd0, 4'd0);
    chk("ld_mop", bus_if.mem_op, 1);
    chk("ld_m2r", bus_if.mem_to_reg, 1);
    chk("ld_rwe", bus_if.reg_write_en, 1);
    tick();
    drive(4'h9, 4'd3, 4'd0, 4'd0);
    wait_issue(n);
    chk("st_stalls", n, 3);
    chk("st_mwe", bus_if.mem_write_en, 1);
    chk("st_mop", bus_if.mem_op, 1);
    chk("st_m2r", bus_if.mem_to_reg, 0);
    chk("st_rwe", bus_if.reg_write_en, 0);
    chk("st_cnt", bus_if.stall_cnt, 6);
    tick();

    // WB dependency: ADD r2, NOP, NOP, SUB r8,r2,r2 -> 1 stall
    drive(4'h1, 4'd2, 4'd0, 4'd0);
    chk("wb_add_stl", bus_if.stall, 0);
    tick();
    drive(4'h0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(4'h0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(4'h2, 4'd8, 4'd2, 4'd2);
    wait_issue(n);
    chk("wb_stalls", n, 1);
    chk("wb_sub_alu", bus_if.alu_sel, 2'b01);
    chk("wb_cnt", bus_if.stall_cnt, 7);
    tick();

    // Illegal opcode 0xA: bubble now, sticky flag from next edge
    drive(4'hA, 4'd1, 4'd1, 4'd1);
    chk("ill_rwe", bus_if.reg_write_en, 0);
    chk("ill_mop", bus_if.mem_op, 0);
    chk("ill_pre", bus_if.illegal, 0);
    tick();
    chk("ill_set", bus_if.illegal, 1);
    drive(4'h4, 4'd9, 4'd10, 4'd11);
    chk("ill_or_rwe", bus_if.reg_write_en, 1);
    tick();
    chk("ill_sticky", bus_if.illegal, 1);

    // HALT: set on the edge, then permanent stall with bubbles
    drive(4'hF, 4'd0, 4'd0, 4'd0);
    chk("hlt_pre", bus_if.halted, 0);
    chk("hlt_stl0", bus_if.stall, 0);
    tick();
    chk("hlt_set", bus_if.halted, 1);
    drive(4'h1, 4'd1, 4'd2, 4'd3);
    chk("hlt_stall", bus_if.stall, 1);
    chk("hlt_bub", bus_if.reg_write_en, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("hlt_stall2", bus_if.stall, 1);
    chk("hlt_hold", bus_if.halted, 1);
    chk("hlt_cnt", bus_if.stall_cnt, 7);

    // Asynchronous reset mid-halt, checked before any clock edge
    rst = 1'b1;
    #1;
    chk("arst_halted", bus_if.halted, 0);
    chk("arst_cnt",    bus_if.stall_cnt, 0);
    chk("arst_ill",    bus_if.illegal, 0);
    chk("arst_stall",  bus_if.stall, 0);
    drive(4'h0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Saturation: 100 ADD/AND pairs, 3 stalls each = 300 stall cycles
    for (int p = 0; p < 100; p++) begin
      drive(4'h1, 4'd1, 4'd2, 4'd3);
      tick();
      drive(4'h3, 4'd5, 4'd1, 4'd1);
      wait_issue(n);
      if (n != 3) chk("sat_pair_stalls", n, 3);
      tick();
    end
    chk("sat_cnt", bus_if.stall_cnt, 8'hFF);
    chk("sat_halted", bus_if.halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
